// File: rtl/pi_if_master_if.sv
// Host-side command/response stream for pi_if_master.
// The master modport issues commands; the slave modport is the pi_if_master port.
interface pi_if_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [1:0] cmd_a;
  logic [7:0] cmd_d;
  logic       rsp_valid;
  logic [7:0] rsp_d;
  logic       rsp_timeout;

  modport master (
    output cmd_valid, cmd_wr, cmd_a, cmd_d,
    input  cmd_ready, rsp_valid, rsp_d, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_a, cmd_d,
    output cmd_ready, rsp_valid, rsp_d, rsp_timeout
  );
endinterface

// File: rtl/pi_if_master.sv
// Pi-side initiator: turns one valid/ready command into one PI_REQ/PI_ACK four-phase access.
// Define PI_IF_MASTER_IRQ_EN to build the PI_IRQ synchronizer and edge detector.
module pi_if_master #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  pi_if_master_if.slave cmd_if,
  output logic          o_pi_req,
  output logic          o_pi_wr,
  output logic [1:0]    o_pi_a,
  input  logic          i_pi_ack,
  inout  wire  [7:0]    io_pi_d,
  input  logic          i_pi_irq,
  output logic          o_irq_level,
  output logic          o_irq_pulse
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);
  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWaitAck,
    StWaitRel,
    StDone
  } state_e;

  state_e          r_state, w_state;
  logic [SetW-1:0] r_set_cnt, w_set_cnt;
  logic [TmoW-1:0] r_tmo_cnt, w_tmo_cnt;
  logic [TmoW-1:0] w_tmo_inc;
  logic            w_tmo_hit;
  logic            r_pi_req, w_pi_req;
  logic            r_pi_wr, w_pi_wr;
  logic [1:0]      r_pi_a, w_pi_a;
  logic [7:0]      r_pi_d, w_pi_d;
  logic            r_pi_d_oe, w_pi_d_oe;
  logic            r_rsp_valid, w_rsp_valid;
  logic [7:0]      r_rsp_d, w_rsp_d;
  logic            r_rsp_timeout, w_rsp_timeout;
  logic            r_ack_s1, r_ack_s2;
  logic            w_cmd_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
    end else begin
      r_ack_s1 <= i_pi_ack;
      r_ack_s2 <= r_ack_s1;
    end
  end

  // Saturating timeout counter; fires one cycle early so PI_REQ drops exactly on expiry.
  assign w_tmo_inc = (r_tmo_cnt == TmoMax) ? r_tmo_cnt : r_tmo_cnt + TmoW'(1);
  assign w_tmo_hit = (r_tmo_cnt >= TmoLast);

  // Never start a new access while the previous acknowledge is still visible.
  assign w_cmd_ready = (r_state == StIdle) && !r_ack_s2;

  always_comb begin
    w_state       = r_state;
    w_set_cnt     = r_set_cnt;
    w_tmo_cnt     = r_tmo_cnt;
    w_pi_req      = r_pi_req;
    w_pi_wr       = r_pi_wr;
    w_pi_a        = r_pi_a;
    w_pi_d        = r_pi_d;
    w_pi_d_oe     = r_pi_d_oe;
    w_rsp_valid   = 1'b0;
    w_rsp_d       = r_rsp_d;
    w_rsp_timeout = r_rsp_timeout;
    unique case (r_state)
      StIdle: begin
        if (cmd_if.cmd_valid && w_cmd_ready) begin
          w_pi_wr       = cmd_if.cmd_wr;
          w_pi_a        = cmd_if.cmd_a;
          w_pi_d        = cmd_if.cmd_d;
          w_pi_d_oe     = cmd_if.cmd_wr;
          w_set_cnt     = '0;
          w_rsp_d       = 8'h00;
          w_rsp_timeout = 1'b0;
          w_state       = StSetup;
        end
      end
      StSetup: begin
        if (r_set_cnt == SetLast) begin
          w_pi_req  = 1'b1;
          w_tmo_cnt = '0;
          w_state   = StWaitAck;
        end else begin
          w_set_cnt = r_set_cnt + SetW'(1);
        end
      end
      StWaitAck: begin
        if (r_ack_s2) begin
          w_pi_req  = 1'b0;
          w_rsp_d   = r_pi_wr ? 8'h00 : io_pi_d;
          w_tmo_cnt = '0;
          w_state   = StWaitRel;
        end else if (w_tmo_hit) begin
          w_pi_req      = 1'b0;
          w_rsp_d       = 8'h00;
          w_rsp_timeout = 1'b1;
          w_tmo_cnt     = '0;
          w_state       = StWaitRel;
        end else begin
          w_tmo_cnt = w_tmo_inc;
        end
      end
      StWaitRel: begin
        if (!r_ack_s2) begin
          w_rsp_valid = 1'b1;
          w_pi_d_oe   = 1'b0;
          w_state     = StDone;
        end else if (w_tmo_hit) begin
          w_rsp_valid   = 1'b1;
          w_rsp_d       = 8'h00;
          w_rsp_timeout = 1'b1;
          w_pi_d_oe     = 1'b0;
          w_state       = StDone;
        end else begin
          w_tmo_cnt = w_tmo_inc;
        end
      end
      StDone: begin
        w_state = StIdle;
      end
      default: begin
        w_state  = StIdle;
        w_pi_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_set_cnt     <= '0;
      r_tmo_cnt     <= '0;
      r_pi_req      <= 1'b0;
      r_pi_wr       <= 1'b0;
      r_pi_a        <= 2'd0;
      r_pi_d        <= 8'h00;
      r_pi_d_oe     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_d       <= 8'h00;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_set_cnt     <= w_set_cnt;
      r_tmo_cnt     <= w_tmo_cnt;
      r_pi_req      <= w_pi_req;
      r_pi_wr       <= w_pi_wr;
      r_pi_a        <= w_pi_a;
      r_pi_d        <= w_pi_d;
      r_pi_d_oe     <= w_pi_d_oe;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_d       <= w_rsp_d;
      r_rsp_timeout <= w_rsp_timeout;
    end
  end

  assign o_pi_req           = r_pi_req;
  assign o_pi_wr            = r_pi_wr;
  assign o_pi_a             = r_pi_a;
  assign io_pi_d            = r_pi_d_oe ? r_pi_d : 8'bz;
  assign cmd_if.cmd_ready   = w_cmd_ready;
  assign cmd_if.rsp_valid   = r_rsp_valid;
  assign cmd_if.rsp_d       = r_rsp_d;
  assign cmd_if.rsp_timeout = r_rsp_timeout;

`ifdef PI_IF_MASTER_IRQ_EN
  logic r_irq_s1, r_irq_s2, r_irq_s3, r_irq_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq_s1    <= 1'b0;
      r_irq_s2    <= 1'b0;
      r_irq_s3    <= 1'b0;
      r_irq_pulse <= 1'b0;
    end else begin
      r_irq_s1    <= i_pi_irq;
      r_irq_s2    <= r_irq_s1;
      r_irq_s3    <= r_irq_s2;
      r_irq_pulse <= r_irq_s2 & ~r_irq_s3;
    end
  end

  assign o_irq_level = r_irq_s2;
  assign o_irq_pulse = r_irq_pulse;
`else
  logic w_unused_irq;
  assign w_unused_irq = i_pi_irq;
  assign o_irq_level  = 1'b0;
  assign o_irq_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_pi_if_master.sv
// Directed bench for pi_if_master with a behavioural CPLD responder.
module tb_pi_if_master;
  localparam int unsigned Settle = 2;
  localparam int unsigned Tmo    = 16;
`ifdef PI_IF_MASTER_IRQ_EN
  localparam logic IrqExp = 1'b1;
`else
  localparam logic IrqExp = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pi_req, pi_wr, irq_level, irq_pulse;
  logic       pi_ack = 1'b0;
  logic       pi_irq = 1'b0;
  logic [1:0] pi_a;
  wire  [7:0] pi_d;
  logic [7:0] rd_val = 8'h00;
  logic       ack_en = 1'b0;
  int         ack_delay = 1;
  int         ack_cnt = 0;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int rsp_cnt = 0, stab_viol = 0, drv_viol = 0, req_ack_viol = 0;
  logic [7:0] rsp_log [16];
  logic       tmo_log [16];
  logic       prev_req = 1'b0, prev_wr = 1'b0;
  logic [1:0] prev_a = 2'd0;
  logic [7:0] prev_d = 8'h00;
  int         base;

  pi_if_master_if cmd_if ();

  pi_if_master #(
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .cmd_if     (cmd_if),
    .o_pi_req   (pi_req),
    .o_pi_wr    (pi_wr),
    .o_pi_a     (pi_a),
    .i_pi_ack   (pi_ack),
    .io_pi_d    (pi_d),
    .i_pi_irq   (pi_irq),
    .o_irq_level(irq_level),
    .o_irq_pulse(irq_pulse)
  );

  always #5 clk = ~clk;

  // CPLD drives the bus whenever a read request is up.
  assign pi_d = (pi_req && !pi_wr) ? rd_val : 8'hzz;

  always @(posedge clk) begin
    if (!pi_req) begin
      pi_ack  <= 1'b0;
      ack_cnt <= 0;
    end else if (ack_en && !pi_ack) begin
      if (ack_cnt == ack_delay - 1) pi_ack <= 1'b1;
      ack_cnt <= ack_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (cmd_if.rsp_valid) begin
      rsp_log[rsp_cnt % 16] <= cmd_if.rsp_d;
      tmo_log[rsp_cnt % 16] <= cmd_if.rsp_timeout;
      rsp_cnt <= rsp_cnt + 1;
    end
    if (pi_req && prev_req &&
        (pi_a != prev_a || pi_wr != prev_wr || (pi_wr && pi_d != prev_d)))
      stab_viol <= stab_viol + 1;
    if (pi_req && !prev_req && pi_ack) req_ack_viol <= req_ack_viol + 1;
    if ((!pi_wr && dut.r_pi_d_oe) || (pi_req && !pi_wr && pi_d !== rd_val))
      drv_viol <= drv_viol + 1;
    prev_req <= pi_req;
    prev_wr  <= pi_wr;
    prev_a   <= pi_a;
    prev_d   <= pi_d;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge with cmd_ready already high; returns just after the accept edge.
  task automatic send(input logic wr, input logic [1:0] a, input logic [7:0] d);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_wr    = wr;
    cmd_if.cmd_a     = a;
    cmd_if.cmd_d     = d;
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int lim);
    int k;
    k = 0;
    while (!cmd_if.rsp_valid && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, cmd_if.rsp_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_wr    = 1'b0;
    cmd_if.cmd_a     = 2'd0;
    cmd_if.cmd_d     = 8'h00;
    cyc(3);
    check("rst_req", {31'd0, pi_req}, 32'd0);
    check("rst_wr", {31'd0, pi_wr}, 32'd0);
    check("rst_a", {30'd0, pi_a}, 32'd0);
    check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, cmd_if.rsp_valid}, 32'd0);
    check("rst_rsp_d", {24'd0, cmd_if.rsp_d}, 32'd0);
    check("rst_rsp_tmo", {31'd0, cmd_if.rsp_timeout}, 32'd0);
    check("rst_irq_level", {31'd0, irq_level}, 32'd0);
    check("rst_irq_pulse", {31'd0, irq_pulse}, 32'd0);
    check("rst_d_oe", {31'd0, dut.r_pi_d_oe}, 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Write A_LO = 0x34, ack 5 cycles after PI_REQ.
    ack_en = 1'b1;
    ack_delay = 5;
    check("wr_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    send(1'b1, 2'd2, 8'h34);
    cyc(1);
    check("wr_e0_a", {30'd0, pi_a}, 32'd2);
    check("wr_e0_wr", {31'd0, pi_wr}, 32'd1);
    check("wr_e0_d", {24'd0, pi_d}, 32'h34);
    check("wr_e0_req", {31'd0, pi_req}, 32'd0);
    check("wr_e0_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    cyc(1);
    check("wr_e1_req", {31'd0, pi_req}, 32'd0);
    cyc(1);
    check("wr_e2_req", {31'd0, pi_req}, 32'd1);
    check("wr_e2_d", {24'd0, pi_d}, 32'h34);
    cyc(7);
    check("wr_e9_req", {31'd0, pi_req}, 32'd1);
    cyc(1);
    check("wr_e10_req", {31'd0, pi_req}, 32'd0);
    cyc(3);
    check("wr_e13_rsp", {31'd0, cmd_if.rsp_valid}, 32'd0);
    cyc(1);
    check("wr_e14_rsp", {31'd0, cmd_if.rsp_valid}, 32'd1);
    check("wr_rsp_tmo", {31'd0, cmd_if.rsp_timeout}, 32'd0);
    check("wr_rsp_d", {24'd0, cmd_if.rsp_d}, 32'd0);
    check("wr_d_released", {31'd0, dut.r_pi_d_oe}, 32'd0);
    cyc(1);
    check("wr_e15_rsp", {31'd0, cmd_if.rsp_valid}, 32'd0);
    check("wr_e15_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("wr_rsp_count", rsp_cnt, 32'd1);

    // Read SRAM, CPLD returns 0xA5; command data 0x5A must never reach the bus.
    rd_val = 8'hA5;
    ack_delay = 3;
    send(1'b0, 2'd0, 8'h5A);
    cyc(1);
    check("rd_e0_oe", {31'd0, dut.r_pi_d_oe}, 32'd0);
    check("rd_e0_wr", {31'd0, pi_wr}, 32'd0);
    cyc(2);
    check("rd_e2_req", {31'd0, pi_req}, 32'd1);
    check("rd_e2_bus", {24'd0, pi_d}, 32'hA5);
    wait_rsp("rd_rsp_valid", 40);
    check("rd_rsp_d", {24'd0, cmd_if.rsp_d}, 32'hA5);
    check("rd_rsp_tmo", {31'd0, cmd_if.rsp_timeout}, 32'd0);
    cyc(1);
    check("rd_no_drive", drv_viol, 32'd0);

    // Timeout: no acknowledge at all.
    ack_en = 1'b0;
    rd_val = 8'h77;
    check("tmo_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    send(1'b0, 2'd1, 8'h00);
    cyc(3);
    check("tmo_e2_req", {31'd0, pi_req}, 32'd1);
    cyc(15);
    check("tmo_e17_req", {31'd0, pi_req}, 32'd1);
    cyc(1);
    check("tmo_e18_req", {31'd0, pi_req}, 32'd0);
    cyc(1);
    check("tmo_rsp_valid", {31'd0, cmd_if.rsp_valid}, 32'd1);
    check("tmo_rsp_tmo", {31'd0, cmd_if.rsp_timeout}, 32'd1);
    check("tmo_rsp_d", {24'd0, cmd_if.rsp_d}, 32'd0);
    cyc(1);

    // Three back-to-back commands with CMD_VALID held high.
    ack_en = 1'b1;
    ack_delay = 2;
    rd_val = 8'hC3;
    base = rsp_cnt;
    for (int i = 0; i < 3; i++) begin
      int k;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_wr    = (i != 1);
      cmd_if.cmd_a     = (i == 0) ? 2'd3 : ((i == 1) ? 2'd1 : 2'd0);
      cmd_if.cmd_d     = (i == 0) ? 8'h12 : ((i == 1) ? 8'h00 : 8'hFF);
      k = 0;
      while (!cmd_if.cmd_ready && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("b2b_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      check("b2b_accept_order", rsp_cnt - base, i);
      @(posedge clk);
      #1;
    end
    cmd_if.cmd_valid = 1'b0;
    for (int k = 0; k < 200 && (rsp_cnt - base) < 3; k++) @(negedge clk);
    check("b2b_rsp_count", rsp_cnt - base, 32'd3);
    check("b2b_rsp0_d", {24'd0, rsp_log[base % 16]}, 32'h00);
    check("b2b_rsp1_d", {24'd0, rsp_log[(base + 1) % 16]}, 32'hC3);
    check("b2b_rsp2_d", {24'd0, rsp_log[(base + 2) % 16]}, 32'h00);
    check("b2b_rsp1_tmo", {31'd0, tmo_log[(base + 1) % 16]}, 32'd0);
    check("b2b_stable", stab_viol, 32'd0);
    check("b2b_req_ack", req_ack_viol, 32'd0);
    check("b2b_no_drive", drv_viol, 32'd0);
    cyc(2);

    // Reset while PI_REQ is high.
    ack_delay = 8;
    send(1'b0, 2'd1, 8'h00);
    cyc(3);
    check("rr_req_up", {31'd0, pi_req}, 32'd1);
    cyc(2);
    base = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check("rr_req_async", {31'd0, pi_req}, 32'd0);
    check("rr_oe", {31'd0, dut.r_pi_d_oe}, 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    check("rr_no_rsp", rsp_cnt - base, 32'd0);
    check("rr_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    ack_delay = 3;
    rd_val = 8'h01;
    send(1'b0, 2'd1, 8'h00);
    wait_rsp("rr_rd_valid", 40);
    check("rr_rd_d", {24'd0, cmd_if.rsp_d}, 32'h01);
    check("rr_rd_tmo", {31'd0, cmd_if.rsp_timeout}, 32'd0);
    cyc(2);

    // PI_IRQ rising edge.
    pi_irq = 1'b1;
    cyc(1);
    check("irq_e1_level", {31'd0, irq_level}, 32'd0);
    check("irq_e1_pulse", {31'd0, irq_pulse}, 32'd0);
    cyc(1);
    check("irq_e2_level", {31'd0, irq_level}, {31'd0, IrqExp});
    check("irq_e2_pulse", {31'd0, irq_pulse}, 32'd0);
    cyc(1);
    check("irq_e3_pulse", {31'd0, irq_pulse}, {31'd0, IrqExp});
    cyc(1);
    check("irq_e4_pulse", {31'd0, irq_pulse}, 32'd0);
    check("irq_e4_level", {31'd0, irq_level}, {31'd0, IrqExp});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pi_if_master.md
# pi_if_master

Pi-side initiator for the clock port Pi request/acknowledge bus. It turns a simple valid/ready command stream into the four-phase PI_REQ/PI_ACK handshake toward the CPLD. One command is one register access (SRAM data, IRQ, address low or address high), and each command produces exactly one response with the read data or a timeout flag. The block sits in the Pi-side FPGA or bridge logic, between the host command path and the PI_* pins.

## Interface
- SETTLE_CYCLES, 2: cycles PI_A/PI_WR/PI_D are held stable before PI_REQ rises. Minimum 1.
- TIMEOUT_CYCLES, 1024: maximum cycles spent waiting for any PI_ACK edge. Minimum 2.
- CLK  in  1  system clock; the only clock.
- RESET_n  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  command accepted on a CLK edge when VALID && READY.
- CMD_WR  in  1  1 = write, 0 = read.
- CMD_A  in  2  register: 0 SRAM, 1 IRQ, 2 A_LO, 3 A_HI.
- CMD_D  in  8  write data.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_D  out  8  read data; 0x00 for writes and for timeouts.
- RSP_TIMEOUT  out  1  qualified by RSP_VALID.
- PI_REQ  out  1  request to the CPLD.
- PI_WR  out  1  direction to the CPLD.
- PI_A  out  2  register address to the CPLD.
- PI_ACK  in  1  asynchronous acknowledge from the CPLD.
- PI_D  inout  8  data bus; the master drives it only for writes.
- PI_IRQ  in  1  asynchronous interrupt level from the CPLD.
- IRQ_LEVEL  out  1  synchronized PI_IRQ.
- IRQ_PULSE  out  1  one-cycle pulse on each PI_IRQ rising edge.

## Operation
- PI_ACK passes through a 2-flop synchronizer to produce ack_s. PI_IRQ passes through its own 2-flop synchronizer.
- States:
  - IDLE: CMD_READY=1. On accept, latch WR, A and D; drive PI_A and PI_WR; enable the PI_D driver only if WR=1; go to SETUP.
  - SETUP: count SETTLE_CYCLES, then set PI_REQ=1, clear the timeout counter and go to WAIT_ACK.
  - WAIT_ACK: when ack_s=1, latch PI_D into RSP_D if it is a read (0x00 if a write), set PI_REQ=0 and go to WAIT_REL. When the counter reaches TIMEOUT_CYCLES first, set PI_REQ=0, set the timeout flag and go to WAIT_REL.
  - WAIT_REL: clear the counter on entry. When ack_s=0, go to DONE. On counter expiry, set the timeout flag and go to DONE.
  - DONE: pulse RSP_VALID, release PI_D to hi-Z, go to IDLE.
- PI_A, PI_WR and the PI_D drive value must not change while PI_REQ=1 or while ack_s=1.
- The PI_D driver is never enabled while PI_WR=0, because the CPLD drives PI_D whenever PI_REQ && !PI_WR.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide, saturates and does not wrap.
- A timed-out command reports RSP_D=0x00 and RSP_TIMEOUT=1. A new command is never issued while ack_s=1.
- CMD_VALID asserted outside IDLE is ignored; upstream holds the command until it is accepted.
- Reset values: PI_REQ=0, PI_WR=0, PI_A=0, PI_D hi-Z, CMD_READY=1, RSP_VALID=0, RSP_D=0x00, RSP_TIMEOUT=0, IRQ_LEVEL=0, IRQ_PULSE=0. The state returns to IDLE and the synchronizers clear.
- Reset during a transfer drops PI_REQ immediately and produces no response. The CPLD completes and clears its own PI_ACK.

## Timing
- Command accepted at edge 0. PI_A, PI_WR and PI_D are valid after edge 0. PI_REQ rises at edge SETTLE_CYCLES.
- PI_ACK rise to PI_REQ fall: 3 edges (2 for the synchronizer, 1 for the registered output). PI_ACK fall to RSP_VALID: 3 edges.
- CMD_READY returns 1 in the cycle after the RSP_VALID pulse.
- Read data is sampled in the same edge that sees ack_s=1. The CPLD holds PI_D valid until PI_REQ falls.
- PI_IRQ rise to IRQ_PULSE: 3 edges. IRQ_LEVEL follows PI_IRQ with a 2-edge lag.

## Configuration
- PI_IF_MASTER_IRQ_EN:
  - Defined: the PI_IRQ synchronizer and edge detector are built, and IRQ_LEVEL/IRQ_PULSE behave as described under Operation.
  - Undefined: PI_IRQ is ignored, IRQ_LEVEL and IRQ_PULSE are tied to 0, and no IRQ flops are built.
  - The command and handshake behaviour is identical in both cases.

## Test plan
- Write A_LO: CMD_WR=1, CMD_A=2, CMD_D=0x34, and the CPLD model acks 5 cycles after PI_REQ rises.
  - PI_A=2, PI_WR=1 and PI_D=0x34 are stable at least 2 cycles before PI_REQ rises.
  - Exactly one RSP_VALID with RSP_TIMEOUT=0 and RSP_D=0x00; PI_D is hi-Z afterwards.
- Read SRAM: CMD_WR=0, CMD_A=0, and the model drives 0xA5 with ACK.
  - RSP_D=0xA5.
  - The master never drives PI_D at any point during the transfer.
- Timeout with TIMEOUT_CYCLES=16 and no ACK from the model:
  - PI_REQ falls 16 cycles after it rose.
  - RSP_VALID with RSP_TIMEOUT=1 and RSP_D=0x00.
- Three back-to-back commands with CMD_VALID held high:
  - Each is accepted only after the previous RSP_VALID.
  - PI_REQ never rises while ack_s=1.
  - PI_A and PI_WR never change while PI_REQ=1.
- Assert RESET_n low while PI_REQ=1:
  - PI_REQ drops to 0 asynchronously and no RSP_VALID is produced.
  - After reset, a read of register 1 returning 0x01 completes normally.
- With PI_IF_MASTER_IRQ_EN defined, raise PI_IRQ:
  - IRQ_PULSE is high for exactly 1 cycle, 3 edges later, and IRQ_LEVEL=1.
  - With the macro undefined, both IRQ outputs stay at 0.
